// File: rtl/store_buffer_if.sv
// -----------------------------------------------------------------------------
// store_buffer_if
//
// Purpose : Bundles every non-clock signal of the store buffer. The M stage
//           pushes stores and issues forwarding lookups, and the dcache accepts
//           the drained head entry.
//
// Modports:
//   slave  - the store buffer itself
//   master - the environment (M stage + dcache) driving the buffer
//
// Signals:
//   push_valid/push_addr/push_data/push_is_byte -> store presented by M
//   push_ready                                  <- buffer can accept a store
//   ld_valid/ld_addr/ld_is_byte                 -> load lookup from M
//   fwd_hit/fwd_data/fwd_stall                  <- forwarding result
//   dc_req/dc_addr/dc_data/dc_is_byte           <- head entry to the dcache
//   dc_ack                                      -> dcache accepted the head
//   empty/count                                 <- occupancy
// -----------------------------------------------------------------------------
interface store_buffer_if #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int ENTRIES       = 4,
  parameter int PTR_WIDTH     = $clog2(ENTRIES)
) ();

  // Store push from the M stage
  logic                     push_valid;
  logic [ADDRESS_WIDTH-1:0] push_addr;
  logic [WORD_WIDTH-1:0]    push_data;
  logic                     push_is_byte;
  logic                     push_ready;

  // Load forwarding lookup
  logic                     ld_valid;
  logic [ADDRESS_WIDTH-1:0] ld_addr;
  logic                     ld_is_byte;
  logic                     fwd_hit;
  logic [WORD_WIDTH-1:0]    fwd_data;
  logic                     fwd_stall;

  // Drain towards the dcache
  logic                     dc_req;
  logic [ADDRESS_WIDTH-1:0] dc_addr;
  logic [WORD_WIDTH-1:0]    dc_data;
  logic                     dc_is_byte;
  logic                     dc_ack;

  // Occupancy
  logic                     empty;
  logic [PTR_WIDTH:0]       count;

  modport slave (
    input  push_valid, push_addr, push_data, push_is_byte,
    output push_ready,
    input  ld_valid, ld_addr, ld_is_byte,
    output fwd_hit, fwd_data, fwd_stall,
    output dc_req, dc_addr, dc_data, dc_is_byte,
    input  dc_ack,
    output empty, count
  );

  modport master (
    output push_valid, push_addr, push_data, push_is_byte,
    input  push_ready,
    output ld_valid, ld_addr, ld_is_byte,
    input  fwd_hit, fwd_data, fwd_stall,
    input  dc_req, dc_addr, dc_data, dc_is_byte,
    output dc_ack,
    input  empty, count
  );

endinterface

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Purpose : In-order FIFO of committed stores sitting between the M stage and
//           the data cache. Stores retire from M in one cycle, drain to the
//           dcache one per cycle over a req/ack handshake, and buffered data is
//           forwarded to younger loads. A word load that overlaps a buffered
//           byte store cannot be assembled here and is stalled instead.
//
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high; discards every buffered entry
//   bus   - store_buffer_if.slave (push, load lookup, dcache drain, occupancy)
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int ENTRIES       = 4,
  parameter int PTR_WIDTH     = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               reset,
  store_buffer_if.slave      bus
);

  localparam int CW = PTR_WIDTH + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ADDRESS_WIDTH-1:0] r_addr [ENTRIES];
  logic [WORD_WIDTH-1:0]    r_data [ENTRIES];
  logic [ENTRIES-1:0]       r_is_byte;

  logic [PTR_WIDTH-1:0]     r_wr_ptr;
  logic [PTR_WIDTH-1:0]     r_rd_ptr;
  logic [CW-1:0]            r_count;

  logic w_empty;
  logic w_push_ready;
  logic w_push;
  logic w_pop;

  // Full/empty come from the count, so equal pointers are never ambiguous.
  assign w_empty      = (r_count == '0);
  // Depends on registered state only: a pop in the same cycle does not
  // open a slot until the following cycle.
  assign w_push_ready = (r_count < CW'(ENTRIES));
  assign w_push       = bus.push_valid && w_push_ready;
  assign w_pop        = !w_empty && bus.dc_ack;

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // ENTRIES is a power of two, so natural overflow wraps the pointers.
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: validity is tracked by pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr]    <= bus.push_addr;
      r_data[r_wr_ptr]    <= bus.push_data;
      r_is_byte[r_wr_ptr] <= bus.push_is_byte;
    end
  end

  // ---------------------------------------------------------------------------
  // Drain port: head entry, forced to zero when nothing is held
  // ---------------------------------------------------------------------------
  assign bus.dc_req     = !w_empty;
  assign bus.dc_addr    = w_empty ? '0   : r_addr[r_rd_ptr];
  assign bus.dc_data    = w_empty ? '0   : r_data[r_rd_ptr];
  assign bus.dc_is_byte = w_empty ? 1'b0 : r_is_byte[r_rd_ptr];

  assign bus.push_ready = w_push_ready;
  assign bus.empty      = w_empty;
  assign bus.count      = r_count;

  // ---------------------------------------------------------------------------
  // Forwarding: evaluate every slot by age (0 = oldest), then let the
  // youngest deciding slot win.
  // ---------------------------------------------------------------------------
  logic [PTR_WIDTH-1:0]  w_age_idx   [ENTRIES];
  logic [WORD_WIDTH-1:0] w_shifted   [ENTRIES];
  logic [7:0]            w_lane_byte [ENTRIES];
  logic [WORD_WIDTH-1:0] w_ent_data  [ENTRIES];
  logic [ENTRIES-1:0]    w_age_valid;
  logic [ENTRIES-1:0]    w_match;
  logic [ENTRIES-1:0]    w_ent_hit;
  logic [ENTRIES-1:0]    w_ent_stall;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_slot
      assign w_age_idx[gi]   = r_rd_ptr + PTR_WIDTH'(gi);
      assign w_age_valid[gi] = (CW'(gi) < r_count);
      assign w_match[gi]     = w_age_valid[gi] &&
                               (r_addr[w_age_idx[gi]][ADDRESS_WIDTH-1:2] ==
                                bus.ld_addr[ADDRESS_WIDTH-1:2]);

      // Byte lane of a word store selected by the load's byte offset.
      assign w_shifted[gi]   = r_data[w_age_idx[gi]] >> {bus.ld_addr[1:0], 3'b000};
      assign w_lane_byte[gi] = r_is_byte[w_age_idx[gi]] ? r_data[w_age_idx[gi]][7:0]
                                                        : w_shifted[gi][7:0];

      // A byte store only covers a byte load at the same offset; a byte
      // store at another offset leaves the search running.
      assign w_ent_hit[gi] = w_match[gi] &&
                             (!r_is_byte[w_age_idx[gi]] ||
                              (bus.ld_is_byte &&
                               (r_addr[w_age_idx[gi]][1:0] == bus.ld_addr[1:0])));
      // A word load cannot be assembled from a single buffered byte.
      assign w_ent_stall[gi] = w_match[gi] && r_is_byte[w_age_idx[gi]] && !bus.ld_is_byte;

      assign w_ent_data[gi] = bus.ld_is_byte
                              ? {{(WORD_WIDTH-8){1'b0}}, w_lane_byte[gi]}
                              : r_data[w_age_idx[gi]];
    end
  endgenerate

  logic                  w_hit;
  logic                  w_stall;
  logic [WORD_WIDTH-1:0] w_fwd_data;

  always_comb begin
    w_hit      = 1'b0;
    w_stall    = 1'b0;
    w_fwd_data = '0;
    // Oldest to youngest: later (younger) deciding slots override earlier ones.
    for (int k = 0; k < ENTRIES; k++) begin
      if (w_ent_hit[k] || w_ent_stall[k]) begin
        w_hit      = w_ent_hit[k];
        w_stall    = w_ent_stall[k];
        w_fwd_data = w_ent_data[k];
      end
    end
  end

  assign bus.fwd_hit   = bus.ld_valid && w_hit;
  assign bus.fwd_stall = bus.ld_valid && w_stall;
  assign bus.fwd_data  = (bus.ld_valid && w_hit) ? w_fwd_data : '0;

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//
// Purpose : Self-checking bench for store_buffer. A queue of stores is the
//           reference: the head is what the dcache must see, and forwarding is
//           computed by scanning that queue from youngest to oldest.
// -----------------------------------------------------------------------------
module tb_store_buffer;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        isb;
  } ent_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  ent_t q[$];

  store_buffer_if #(.WORD_WIDTH(32), .ADDRESS_WIDTH(32), .ENTRIES(4)) bus ();

  store_buffer #(
    .WORD_WIDTH(32), .ADDRESS_WIDTH(32), .ENTRIES(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Forwarding result from the queue contents, youngest entry first.
  function automatic void model_fwd(output logic hit, output logic stall, output logic [31:0] d);
    hit = 1'b0; stall = 1'b0; d = 32'h0;
    if (bus.ld_valid !== 1'b1) return;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].addr[31:2] == bus.ld_addr[31:2]) begin
        if (!q[i].isb) begin
          hit = 1'b1;
          d = bus.ld_is_byte ? ((q[i].data >> (8 * bus.ld_addr[1:0])) & 32'hFF) : q[i].data;
          return;
        end else if (!bus.ld_is_byte) begin
          stall = 1'b1;
          return;
        end else if (q[i].addr[1:0] == bus.ld_addr[1:0]) begin
          hit = 1'b1;
          d = {24'h0, q[i].data[7:0]};
          return;
        end
      end
    end
  endfunction

  task automatic check_outputs(input string tag);
    logic hit, stall;
    logic [31:0] d;
    ent_t head;
    head = (q.size() > 0) ? q[0] : '0;
    model_fwd(hit, stall, d);
    chk({tag, ".ready"},  bus.push_ready, (q.size() < 4) ? 32'd1 : 32'd0);
    chk({tag, ".empty"},  bus.empty,      (q.size() == 0) ? 32'd1 : 32'd0);
    chk({tag, ".count"},  bus.count,      q.size());
    chk({tag, ".dc_req"}, bus.dc_req,     (q.size() > 0) ? 32'd1 : 32'd0);
    chk({tag, ".dc_addr"}, bus.dc_addr,   head.addr);
    chk({tag, ".dc_data"}, bus.dc_data,   head.data);
    chk({tag, ".dc_isb"}, bus.dc_is_byte, head.isb);
    chk({tag, ".hit"},    bus.fwd_hit,    hit);
    chk({tag, ".stall"},  bus.fwd_stall,  stall);
    chk({tag, ".fdata"},  bus.fwd_data,   d);
  endtask

  // One clock: check current outputs, take the edge, update the model.
  task automatic tick(input string tag);
    logic do_push, do_pop;
    #1;
    check_outputs(tag);
    do_pop  = bus.dc_ack && (q.size() > 0);
    do_push = bus.push_valid && (q.size() < 4);
    @(posedge clk);
    if (reset) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{addr: bus.push_addr, data: bus.push_data, isb: bus.push_is_byte});
    end
    $display("[TB] %s: push=%0b ack=%0b ld=%0b@%h -> count=%0d", tag,
             do_push, do_pop, bus.ld_valid, bus.ld_addr, q.size());
    @(negedge clk);
  endtask

  task automatic set_push(input logic v, input logic [31:0] a, input logic [31:0] d, input logic b);
    bus.push_valid = v; bus.push_addr = a; bus.push_data = d; bus.push_is_byte = b;
  endtask

  // Load lookup with constant expectations, then one modelled cycle.
  task automatic look(input string tag, input logic [31:0] a, input logic b,
                      input logic eh, input logic es, input logic [31:0] ed);
    bus.ld_valid = 1'b1; bus.ld_addr = a; bus.ld_is_byte = b;
    #1;
    chk({tag, ".c_hit"},   bus.fwd_hit,   eh);
    chk({tag, ".c_stall"}, bus.fwd_stall, es);
    if (eh) chk({tag, ".c_data"}, bus.fwd_data, ed);
    tick(tag);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    set_push(1'b0, 32'h0, 32'h0, 1'b0);
    bus.ld_valid = 1'b0; bus.ld_addr = 32'h0; bus.ld_is_byte = 1'b0;
    bus.dc_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    #1;
    chk("rst.ready",   bus.push_ready, 32'd1);
    chk("rst.empty",   bus.empty,      32'd1);
    chk("rst.count",   bus.count,      32'd0);
    chk("rst.dc_req",  bus.dc_req,     32'd0);
    chk("rst.dc_addr", bus.dc_addr,    32'd0);
    chk("rst.dc_data", bus.dc_data,    32'd0);
    chk("rst.fwd",     {bus.fwd_hit, bus.fwd_stall}, 32'd0);
    chk("rst.fdata",   bus.fwd_data,   32'd0);

    // Single store then ack
    set_push(1'b1, 32'h4, 32'h2, 1'b0);
    tick("t1.push");
    set_push(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("t1.count", bus.count, 32'd1);
    chk("t1.dc_req", bus.dc_req, 32'd1);
    chk("t1.dc_addr", bus.dc_addr, 32'h4);
    chk("t1.dc_data", bus.dc_data, 32'h2);
    bus.dc_ack = 1'b1;
    tick("t1.ack");
    bus.dc_ack = 1'b0;
    #1;
    chk("t1.empty", bus.empty, 32'd1);

    // Fill, ignored 5th push, in-order drain
    for (int i = 0; i < 4; i++) begin
      set_push(1'b1, 32'(4 * i), $urandom, 1'b0);
      tick("t2.fill");
    end
    set_push(1'b1, 32'h10, 32'hDEAD, 1'b0);
    #1;
    chk("t2.full_ready", bus.push_ready, 32'd0);
    chk("t2.full_count", bus.count, 32'd4);
    tick("t2.push5");
    set_push(1'b0, 32'h0, 32'h0, 1'b0);
    bus.dc_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2.order", bus.dc_addr, 32'(4 * i));
      tick("t2.drain");
      if (i == 0) chk("t2.ready_after_ack", bus.push_ready, 32'd1);
    end

    // Streaming with dc_ack held high: pointers wrap, nothing lost
    for (int i = 0; i < 6; i++) begin
      set_push(1'b1, 32'h20 + 32'(4 * i), $urandom, 1'b0);
      tick("t3.stream");
      chk("t3.count_le1", (bus.count <= 1) ? 32'd1 : 32'd0, 32'd1);
    end
    set_push(1'b0, 32'h0, 32'h0, 1'b0);
    tick("t3.tail");
    bus.dc_ack = 1'b0;

    // Forwarding: sw 0x8 <- 0x11223344, sb 0x9 <- 0xAA
    set_push(1'b1, 32'h8, 32'h11223344, 1'b0);
    tick("t4.sw");
    set_push(1'b1, 32'h9, 32'h000000AA, 1'b1);
    tick("t4.sb");
    set_push(1'b0, 32'h0, 32'h0, 1'b0);
    look("t4.lb9",  32'h9,  1'b1, 1'b1, 1'b0, 32'hAA);
    look("t4.lbA",  32'hA,  1'b1, 1'b1, 1'b0, 32'h22);
    look("t4.lw8",  32'h8,  1'b0, 1'b0, 1'b1, 32'h0);
    look("t4.lw10", 32'h10, 1'b0, 1'b0, 1'b0, 32'h0);
    bus.ld_addr = 32'h8; bus.ld_is_byte = 1'b0;
    bus.dc_ack = 1'b1;
    tick("t4.drain0");
    tick("t4.drain1");
    look("t4.lw8_resolved", 32'h8, 1'b0, 1'b0, 1'b0, 32'h0);
    bus.dc_ack = 1'b0;

    // Youngest wins; same-cycle push is not forwarded
    set_push(1'b1, 32'h4, 32'h1, 1'b0);
    tick("t5.sw1");
    set_push(1'b1, 32'h4, 32'h7, 1'b0);
    tick("t5.sw7");
    set_push(1'b1, 32'h4, 32'h9, 1'b0);
    look("t5.lw_same_cycle", 32'h4, 1'b0, 1'b1, 1'b0, 32'h7);
    set_push(1'b0, 32'h0, 32'h0, 1'b0);
    look("t5.lw_next", 32'h4, 1'b0, 1'b1, 1'b0, 32'h9);
    bus.ld_valid = 1'b0;

    // Reset mid-drain
    bus.dc_ack = 1'b1;
    repeat (3) tick("t6.drain");
    bus.dc_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_push(1'b1, 32'h40 + 32'(4 * i), $urandom, 1'b0);
      tick("t6.fill");
    end
    set_push(1'b0, 32'h0, 32'h0, 1'b0);
    bus.dc_ack = 1'b1;
    tick("t6.ack");
    reset = 1'b1;
    tick("t6.reset");
    reset = 1'b0;
    #1;
    chk("t6.count", bus.count, 32'd0);
    chk("t6.dc_req", bus.dc_req, 32'd0);
    chk("t6.ready", bus.push_ready, 32'd1);
    repeat (2) tick("t6.after");
    bus.dc_ack = 1'b0;

    // Randomized traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      logic b;
      logic [31:0] a;
      b = 1'($urandom_range(0, 1));
      a = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
      if (b) a[1:0] = 2'($urandom_range(0, 3));
      set_push(($urandom_range(0, 99) < 55), a, $urandom, b);
      bus.dc_ack     = ($urandom_range(0, 99) < 45);
      bus.ld_valid   = ($urandom_range(0, 99) < 80);
      bus.ld_is_byte = 1'($urandom_range(0, 1));
      bus.ld_addr    = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
      if (bus.ld_is_byte) bus.ld_addr[1:0] = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 99) == 0);
      tick("rnd");
    end
    reset = 1'b0;
    set_push(1'b0, 32'h0, 32'h0, 1'b0);
    bus.ld_valid = 1'b0;
    bus.dc_ack = 1'b0;
    tick("end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO of committed stores between the memory (M) stage and the data cache.
- Lets `sw`/`sb` retire from M in one cycle and drains them to the dcache in order, one per cycle, using a req/ack handshake.
- Forwards buffered store data to younger loads in M; stalls loads it cannot satisfy safely.

Parameters:
- WORD_WIDTH, 32, data width in bits.
- ADDRESS_WIDTH, 32, byte address width.
- ENTRIES, 4, buffer depth; power of two, ≥2.
- PTR_WIDTH, $clog2(ENTRIES), read/write pointer width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- push_valid  in  1  M stage presents a store.
- push_addr  in  ADDRESS_WIDTH  store byte address.
- push_data  in  WORD_WIDTH  store data; byte stores use [7:0].
- push_is_byte  in  1  1 = byte store, 0 = word store.
- push_ready  out  1  buffer can accept a store this cycle.
- ld_valid  in  1  M stage presents a load for forwarding lookup.
- ld_addr  in  ADDRESS_WIDTH  load byte address.
- ld_is_byte  in  1  1 = byte load, 0 = word load.
- fwd_hit  out  1  fwd_data is valid for this load.
- fwd_data  out  WORD_WIDTH  forwarded data; byte loads return the byte in [7:0] with upper bits zero.
- fwd_stall  out  1  load partially overlaps a buffered store; M must stall.
- dc_req  out  1  head entry presented to the dcache.
- dc_addr  out  ADDRESS_WIDTH  head entry address.
- dc_data  out  WORD_WIDTH  head entry data.
- dc_is_byte  out  1  head entry size.
- dc_ack  in  1  dcache accepted the head entry this cycle.
- empty  out  1  no entries held.
- count  out  PTR_WIDTH+1  number of entries held.

Behaviour:
- Reset (synchronous, active-high) clears wr_ptr, rd_ptr and count to 0.
  - After reset: push_ready=1, empty=1, dc_req=0, fwd_hit=0, fwd_stall=0.
  - dc_addr, dc_data, dc_is_byte, fwd_data read 0 after reset.
- Reset during a pending drain discards all entries; dc_req drops the cycle after the reset edge.
- push_ready = (count < ENTRIES), taken from registered state only; it has no combinational dependence on dc_ack.
- Enqueue:
  - When push_valid && push_ready at a rising edge, write the entry at wr_ptr and increment wr_ptr modulo ENTRIES.
  - push_valid while full is ignored; the M stage must hold the store.
- Drain:
  - dc_req = !empty; dc_* reflect the entry at rd_ptr.
  - When dc_req && dc_ack at a rising edge, increment rd_ptr modulo ENTRIES.
  - dc_* stay stable while dc_req=1 and dc_ack=0.
  - dc_ack while empty is ignored.
  - Maximum drain rate is one entry per cycle.
- Simultaneous push accept and pop: count unchanged and both pointers advance.
  - When full, the pop frees a slot only from the next cycle on.
- Pointer wrap: pointers wrap ENTRIES-1 → 0. Full and empty are distinguished by count, not by pointer equality.
- Alignment: word accesses have addr[1:0]=00 (enforced by the decode stage). Misaligned words are undefined here.
- Forwarding (combinational; registered contents only, never the store being pushed in the same cycle):
  - The search runs youngest → oldest over the valid entries.
  - An entry is a candidate when its word address [ADDRESS_WIDTH-1:2] equals that of ld_addr.
  - Word store, word load: hit; fwd_data = store data.
  - Word store, byte load: hit; fwd_data = {24'b0, store data byte selected by ld_addr[1:0]}.
  - Byte store, byte load, same byte offset: hit; fwd_data = {24'b0, data[7:0]}.
  - Byte store, byte load, different byte offset: no overlap; continue to the next older entry.
  - Byte store, word load: fwd_stall=1, fwd_hit=0. The stall resolves once that entry drains.
  - The first candidate that hits or stalls decides the result.
  - No candidate: fwd_hit=0, fwd_stall=0, and the load proceeds to the dcache.
  - ld_valid=0 forces fwd_hit=0 and fwd_stall=0.
- A head entry popping in the same cycle is still searched; the result is valid for that cycle.
- Design target: 150–250 lines of RTL.

Test Plan:
- Reset, then push sw addr 0x4 data 0x2 with dc_ack=0 → next cycle count=1, dc_req=1, dc_addr=0x4, dc_data=0x2; assert dc_ack → empty=1 one cycle later.
- Push 4 word stores (0x0, 0x4, 0x8, 0xC) with dc_ack=0 → push_ready=0 and count=4. A 5th push is ignored. One ack → push_ready=1 the next cycle. Drain order is 0x0, 0x4, 0x8, 0xC.
- Hold dc_ack=1 while pushing 6 stores back to back → count stays ≤1, pointers wrap, and the dcache sees all 6 in order with no loss.
- Buffer holds sw 0x8←0x11223344 then sb 0x9←0xAA:
  - lb 0x9 → fwd_hit=1, fwd_data=0xAA.
  - lb 0xA → fwd_hit=1, fwd_data=0x22.
  - lw 0x8 → fwd_stall=1, fwd_hit=0.
  - lw 0x10 → fwd_hit=0, fwd_stall=0.
- Two sw to 0x4 (0x1, then 0x7) → lw 0x4 returns 0x7. The same-cycle push of 0x9 to 0x4 is not visible until the next cycle.
- Fill 3 entries, assert reset mid-drain → next cycle count=0, dc_req=0, push_ready=1, and prior entries are never presented again.
